// File: rtl/ht_cmd_arbiter.sv
// Round-robin arbiter sharing one hash-table command/result port between REQ_CNT requesters.
// Results return in order and are routed by a tag FIFO; OP_INIT is serialized against all traffic.
package hash_table;
   typedef enum logic [1:0] {
      OP_INIT   = 2'd0,
      OP_SEARCH = 2'd1,
      OP_INSERT = 2'd2,
      OP_DELETE = 2'd3
   } opcode_e;
endpackage

module ht_cmd_arbiter #(
   parameter int REQ_CNT      = 4,
   parameter int KEY_WIDTH    = 32,
   parameter int VALUE_WIDTH  = 16,
   parameter int OPCODE_WIDTH = 2,
   parameter int RES_WIDTH    = 64,
   parameter int MAX_INFLIGHT = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [REQ_CNT-1:0]              req_valid_i,
   input  logic [REQ_CNT*OPCODE_WIDTH-1:0] req_opcode_i,
   input  logic [REQ_CNT*KEY_WIDTH-1:0]    req_key_i,
   input  logic [REQ_CNT*VALUE_WIDTH-1:0]  req_value_i,
   output logic [REQ_CNT-1:0]              req_ready_o,
   output logic                            cmd_valid_o,
   output logic [OPCODE_WIDTH-1:0]         cmd_opcode_o,
   output logic [KEY_WIDTH-1:0]            cmd_key_o,
   output logic [VALUE_WIDTH-1:0]          cmd_value_o,
   input  logic                            cmd_ready_i,
   input  logic                            res_valid_i,
   input  logic [RES_WIDTH-1:0]            res_data_i,
   output logic                            res_ready_o,
   output logic [REQ_CNT-1:0]              rsp_valid_o,
   output logic [RES_WIDTH-1:0]            rsp_data_o,
   input  logic [REQ_CNT-1:0]              rsp_ready_i,
   output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
   output logic                            orphan_err_o
);

   localparam int IDW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam int PW  = $clog2(MAX_INFLIGHT);
   localparam int CW  = PW + 1;
   localparam logic [CW-1:0]           FULL_CNT  = CW'(MAX_INFLIGHT);
   localparam logic [OPCODE_WIDTH-1:0] W_OP_INIT = OPCODE_WIDTH'(hash_table::OP_INIT);

   typedef enum logic [1:0] {ARB, DRAIN, INIT_WAIT} state_t;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] op;
      logic [KEY_WIDTH-1:0]    key;
      logic [VALUE_WIDTH-1:0]  val;
   } cmd_t;

   state_t                r_state;
   logic [IDW-1:0]        r_rr_ptr;
   logic [IDW-1:0]        r_init_id;
   logic [IDW-1:0]        r_fifo [MAX_INFLIGHT];
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_inflight;
   logic                  r_cmd_valid;
   cmd_t                  r_cmd;
   logic                  r_orphan;

   cmd_t [REQ_CNT-1:0]    w_req;
   state_t                w_state_nx;
   logic [IDW-1:0]        w_init_id_nx;
   logic [IDW-1:0]        w_win;
   logic                  w_any;
   logic [IDW-1:0]        w_gid;
   logic [IDW-1:0]        w_rr_nx;
   logic                  w_grant;
   logic                  w_load_ok;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_idle;
   logic [IDW-1:0]        w_head;
   logic                  w_pop;

   for (genvar g = 0; g < REQ_CNT; g++) begin : g_req
      assign w_req[g] = {req_opcode_i[g*OPCODE_WIDTH +: OPCODE_WIDTH],
                         req_key_i[g*KEY_WIDTH +: KEY_WIDTH],
                         req_value_i[g*VALUE_WIDTH +: VALUE_WIDTH]};
   end

   assign w_load_ok = !r_cmd_valid || cmd_ready_i;
   assign w_full    = (r_inflight == FULL_CNT);
   assign w_empty   = (r_inflight == '0);
   // inflight=0 already implies an empty output register, but both are checked for clarity
   assign w_idle    = w_empty && !r_cmd_valid;
   assign w_head    = r_fifo[r_rptr];
   assign w_rr_nx   = (w_gid == IDW'(REQ_CNT-1)) ? '0 : w_gid + IDW'(1);

   // Scan from the highest offset down so the last hit is the lowest index at or after rr_ptr
   always_comb begin
      logic [IDW:0] sum;
      sum   = '0;
      w_any = 1'b0;
      w_win = '0;
      for (int k = REQ_CNT-1; k >= 0; k--) begin
         sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(REQ_CNT)) sum = sum - (IDW+1)'(REQ_CNT);
         if (req_valid_i[sum[IDW-1:0]]) begin
            w_any = 1'b1;
            w_win = sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_init_id_nx = r_init_id;
      w_grant      = 1'b0;
      w_gid        = w_win;
      case (r_state)
         ARB: begin
            if (w_any) begin
               if (w_req[w_win].op == W_OP_INIT) begin
                  if (w_idle) begin
                     w_grant    = 1'b1;
                     w_state_nx = INIT_WAIT;
                  end else begin
                     w_init_id_nx = w_win;
                     w_state_nx   = DRAIN;
                  end
               end else if (w_load_ok && !w_full) begin
                  w_grant = 1'b1;
               end
            end
         end
         DRAIN: begin
            w_gid = r_init_id;
            if (req_valid_i[r_init_id] && w_idle) begin
               w_grant    = 1'b1;
               w_state_nx = INIT_WAIT;
            end
         end
         INIT_WAIT: begin
            if (w_pop && r_inflight == CW'(1)) w_state_nx = ARB;
         end
         default: w_state_nx = ARB;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      if (w_grant) req_ready_o[w_gid] = 1'b1;
   end

   // Result path is purely combinational; an empty FIFO swallows the result as an orphan
   always_comb begin
      rsp_valid_o = '0;
      if (res_valid_i && !w_empty) rsp_valid_o[w_head] = 1'b1;
   end

   assign rsp_data_o  = res_data_i;
   assign res_ready_o = w_empty ? res_valid_i : rsp_ready_i[w_head];
   assign w_pop       = res_valid_i && !w_empty && rsp_ready_i[w_head];

   always_ff @(posedge clk_i) begin
      if (w_grant) r_fifo[r_wptr] <= w_gid;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ARB;
         r_rr_ptr    <= '0;
         r_init_id   <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_inflight  <= '0;
         r_cmd_valid <= 1'b0;
         r_cmd       <= '0;
         r_orphan    <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_init_id <= w_init_id_nx;
         if (w_grant) begin
            r_rr_ptr <= w_rr_nx;
            r_wptr   <= r_wptr + PW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         case ({w_grant, w_pop})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         if (w_grant) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= w_req[w_gid];
         end else if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
         end
         if (res_valid_i && w_empty) r_orphan <= 1'b1;
      end
   end

   assign cmd_valid_o  = r_cmd_valid;
   assign cmd_opcode_o = r_cmd.op;
   assign cmd_key_o    = r_cmd.key;
   assign cmd_value_o  = r_cmd.val;
   assign inflight_o   = r_inflight;
   assign orphan_err_o = r_orphan;

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed bench for ht_cmd_arbiter: round-robin, routing, INIT drain, backpressure, full, orphan.
module tb_ht_cmd_arbiter;

   localparam logic [1:0] T_INIT   = 2'd0;
   localparam logic [1:0] T_SEARCH = 2'd1;
   localparam logic [1:0] T_INSERT = 2'd2;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [7:0]   req_opcode;
   logic [127:0] req_key;
   logic [63:0]  req_value;
   logic [3:0]   req_ready;
   logic         cmd_valid;
   logic [1:0]   cmd_opcode;
   logic [31:0]  cmd_key;
   logic [15:0]  cmd_value;
   logic         cmd_ready;
   logic         res_valid;
   logic [63:0]  res_data;
   logic         res_ready;
   logic [3:0]   rsp_valid;
   logic [63:0]  rsp_data;
   logic [3:0]   rsp_ready;
   logic [4:0]   inflight;
   logic         orphan;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ht_cmd_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_opcode_i(req_opcode), .req_key_i(req_key),
      .req_value_i(req_value), .req_ready_o(req_ready),
      .cmd_valid_o(cmd_valid), .cmd_opcode_o(cmd_opcode), .cmd_key_o(cmd_key),
      .cmd_value_o(cmd_value), .cmd_ready_i(cmd_ready),
      .res_valid_i(res_valid), .res_data_i(res_data), .res_ready_o(res_ready),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
      .inflight_o(inflight), .orphan_err_o(orphan)
   );

   function automatic logic [31:0] key_of(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] key);
      req_opcode[i*2 +: 2]   = op;
      req_key[i*32 +: 32]    = key;
      req_value[i*16 +: 16]  = 16'h0100 + 16'(i);
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = '0; req_opcode = '0; req_key = '0; req_value = '0;
      cmd_ready = 1'b0; res_valid = 1'b0; res_data = '0; rsp_ready = '0;
      tick; tick;
      rst = 1'b0;
      #1;
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
      checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b want 0", orphan); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0 || res_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%b want 0000/0", rsp_valid, res_ready); end
      checks++; if (cmd_key !== 32'h0) begin errors++; $display("FAIL reset_cmd_key got %h want 0", cmd_key); end
   endtask

   task automatic test_round_robin;
      for (int i = 0; i < 4; i++) set_req(i, T_SEARCH, key_of(i));
      cmd_ready = 1'b1; rsp_ready = 4'hF; req_valid = 4'hF;
      for (int n = 0; n < 6; n++) begin
         #1;
         checks++; if (req_ready !== 4'(1 << (n % 4))) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", n, req_ready, 4'(1 << (n % 4))); end
         tick;
         checks++; if (cmd_valid !== 1'b1 || cmd_key !== key_of(n % 4)) begin errors++; $display("FAIL rr_cmd[%0d] got %b/%h want 1/%h", n, cmd_valid, cmd_key, key_of(n % 4)); end
         checks++; if (inflight !== 5'(n + 1)) begin errors++; $display("FAIL rr_inflight[%0d] got %0d want %0d", n, inflight, n + 1); end
      end
      req_valid = '0;
      // head requester not ready: result must stall
      rsp_ready = 4'b1110; res_valid = 1'b1; res_data = 64'h55;
      #1;
      checks++; if (res_ready !== 1'b0 || rsp_valid !== 4'b0001) begin errors++; $display("FAIL rr_stall got %b/%b want 0/0001", res_ready, rsp_valid); end
      tick;
      checks++; if (inflight !== 5'd6 || cmd_valid !== 1'b0) begin errors++; $display("FAIL rr_stall_hold got %0d/%b want 6/0", inflight, cmd_valid); end
      rsp_ready = 4'hF;
      for (int n = 0; n < 6; n++) begin
         res_valid = 1'b1; res_data = 64'hC0DE_0000_0000_0000 | 64'(n);
         #1;
         checks++; if (rsp_valid !== 4'(1 << (n % 4)) || res_ready !== 1'b1) begin errors++; $display("FAIL rr_route[%0d] got %b/%b want %b/1", n, rsp_valid, res_ready, 4'(1 << (n % 4))); end
         checks++; if (rsp_data !== (64'hC0DE_0000_0000_0000 | 64'(n))) begin errors++; $display("FAIL rr_data[%0d] got %h", n, rsp_data); end
         tick;
      end
      res_valid = 1'b0;
      #1;
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL rr_drained got %0d want 0", inflight); end
   endtask

   task automatic test_single_insert;
      set_req(2, T_INSERT, 32'h0100_0000);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ins_grant got %b want 0100", req_ready); end
      tick;
      req_valid = '0;
      checks++; if (cmd_valid !== 1'b1 || cmd_opcode !== T_INSERT || cmd_key !== 32'h0100_0000 || cmd_value !== 16'h0102)
         begin errors++; $display("FAIL ins_cmd got %b/%0d/%h/%h want 1/2/01000000/0102", cmd_valid, cmd_opcode, cmd_key, cmd_value); end
      checks++; if (inflight !== 5'd1) begin errors++; $display("FAIL ins_inflight got %0d want 1", inflight); end
      repeat (4) tick;
      res_valid = 1'b1; res_data = 64'h0123_4567_89AB_CDEF;
      #1;
      checks++; if (rsp_valid !== 4'b0100 || res_ready !== 1'b1) begin errors++; $display("FAIL ins_route got %b/%b want 0100/1", rsp_valid, res_ready); end
      checks++; if (rsp_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ins_data got %h", rsp_data); end
      tick;
      res_valid = 1'b0;
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL ins_done got %0d want 0", inflight); end
   endtask

   task automatic test_init_drain;
      logic [3:0] tags [3];
      tags[0] = 4'b0001; tags[1] = 4'b1000; tags[2] = 4'b0001;
      set_req(0, T_SEARCH, key_of(0));
      set_req(1, T_INIT, key_of(1));
      set_req(3, T_SEARCH, key_of(3));
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL init_pre0 got %b want 0001", req_ready); end
      tick;
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL init_pre1 got %b want 1000", req_ready); end
      tick;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL init_pre2 got %b want 0001", req_ready); end
      tick;
      req_valid = 4'b1011;
      #1;
      checks++; if (req_ready !== 4'b0000 || inflight !== 5'd3) begin errors++; $display("FAIL init_block got %b/%0d want 0000/3", req_ready, inflight); end
      tick;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drain_block got %b want 0000", req_ready); end
      tick;
      for (int k = 0; k < 3; k++) begin
         res_valid = 1'b1; res_data = 64'(k);
         #1;
         checks++; if (rsp_valid !== tags[k] || req_ready !== 4'b0000) begin errors++; $display("FAIL drain_pop[%0d] got %b/%b want %b/0000", k, rsp_valid, req_ready, tags[k]); end
         tick;
      end
      res_valid = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0010 || inflight !== 5'd0) begin errors++; $display("FAIL init_issue got %b/%0d want 0010/0", req_ready, inflight); end
      tick;
      checks++; if (cmd_valid !== 1'b1 || cmd_opcode !== T_INIT || cmd_key !== key_of(1) || inflight !== 5'd1)
         begin errors++; $display("FAIL init_cmd got %b/%0d/%h/%0d want 1/0/%h/1", cmd_valid, cmd_opcode, cmd_key, inflight, key_of(1)); end
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL init_wait0 got %b want 0000", req_ready); end
      tick;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL init_wait1 got %b want 0000", req_ready); end
      res_valid = 1'b1; res_data = 64'hFEED;
      #1;
      checks++; if (rsp_valid !== 4'b0010 || req_ready !== 4'b0000) begin errors++; $display("FAIL init_result got %b/%b want 0010/0000", rsp_valid, req_ready); end
      tick;
      res_valid = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL init_after got %b want 1000", req_ready); end
      tick;
      checks++; if (cmd_key !== key_of(3) || inflight !== 5'd1) begin errors++; $display("FAIL init_after_cmd got %h/%0d want %h/1", cmd_key, inflight, key_of(3)); end
      req_valid = '0;
      res_valid = 1'b1;
      #1;
      checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL init_cleanup got %b want 1000", rsp_valid); end
      tick;
      res_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      int bad;
      bad = 0;
      set_req(1, T_SEARCH, key_of(1));
      set_req(2, T_SEARCH, key_of(2));
      cmd_ready = 1'b0; req_valid = 4'b0110;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first got %b want 0010", req_ready); end
      tick;
      for (int n = 0; n < 10; n++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || cmd_valid !== 1'b1 || cmd_key !== key_of(1)) begin
            errors++; bad++;
            $display("FAIL bp_hold[%0d] got %b/%b/%h want 0000/1/%h", n, req_ready, cmd_valid, cmd_key, key_of(1));
         end
         tick;
      end
      cmd_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got %b want 0100", req_ready); end
      tick;
      checks++; if (cmd_key !== key_of(2) || inflight !== 5'd2) begin errors++; $display("FAIL bp_second got %h/%0d want %h/2", cmd_key, inflight, key_of(2)); end
      req_valid = '0;
      tick;
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", cmd_valid); end
      res_valid = 1'b1;
      #1;
      checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_res0 got %b want 0010", rsp_valid); end
      tick;
      #1;
      checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL bp_res1 got %b want 0100", rsp_valid); end
      tick;
      res_valid = 1'b0;
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL bp_done got %0d want 0", inflight); end
   endtask

   task automatic test_full;
      for (int i = 0; i < 4; i++) set_req(i, T_SEARCH, key_of(i));
      cmd_ready = 1'b1; req_valid = 4'hF;
      for (int n = 0; n < 16; n++) begin
         #1;
         checks++; if (req_ready !== 4'(1 << ((3 + n) % 4))) begin errors++; $display("FAIL full_fill[%0d] got %b want %b", n, req_ready, 4'(1 << ((3 + n) % 4))); end
         tick;
      end
      checks++; if (inflight !== 5'd16 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_stop got %0d/%b want 16/0000", inflight, req_ready); end
      tick;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_hold got %b want 0000", req_ready); end
      res_valid = 1'b1;
      #1;
      checks++; if (rsp_valid !== 4'b1000 || req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop got %b/%b want 1000/0000", rsp_valid, req_ready); end
      tick;
      res_valid = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b1000 || inflight !== 5'd15) begin errors++; $display("FAIL full_one got %b/%0d want 1000/15", req_ready, inflight); end
      tick;
      #1;
      checks++; if (req_ready !== 4'b0000 || inflight !== 5'd16) begin errors++; $display("FAIL full_again got %b/%0d want 0000/16", req_ready, inflight); end
      req_valid = '0;
      for (int i = 0; i < 16; i++) begin
         res_valid = 1'b1;
         #1;
         checks++; if (rsp_valid !== 4'(1 << (i % 4))) begin errors++; $display("FAIL full_drain[%0d] got %b want %b", i, rsp_valid, 4'(1 << (i % 4))); end
         tick;
      end
      res_valid = 1'b0;
      checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL full_done got %0d want 0", inflight); end
   endtask

   task automatic test_orphan;
      set_req(0, T_SEARCH, key_of(0));
      req_valid = 4'b0001;
      tick;
      req_valid = '0;
      checks++; if (inflight !== 5'd1) begin errors++; $display("FAIL orph_pre got %0d want 1", inflight); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++; if (inflight !== 5'd0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL orph_rst got %0d/%b want 0/0", inflight, cmd_valid); end
      res_valid = 1'b1; res_data = 64'hBAD;
      #1;
      checks++; if (res_ready !== 1'b1 || rsp_valid !== 4'b0000 || orphan !== 1'b0) begin errors++; $display("FAIL orph_accept got %b/%b/%b want 1/0000/0", res_ready, rsp_valid, orphan); end
      tick;
      res_valid = 1'b0;
      #1;
      checks++; if (orphan !== 1'b1 || res_ready !== 1'b0) begin errors++; $display("FAIL orph_set got %b/%b want 1/0", orphan, res_ready); end
      repeat (3) tick;
      checks++; if (orphan !== 1'b1 || inflight !== 5'd0) begin errors++; $display("FAIL orph_sticky got %b/%0d want 1/0", orphan, inflight); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL orph_clear got %b want 0", orphan); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_round_robin;
      test_single_insert;
      test_init_drain;
      test_backpressure;
      test_full;
      test_orphan;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
